// File: rtl/sprite_fetch_ctrl.sv
// Once-per-frame fetch of the six sprite-position words from RAM port A.
// All six words are staged and then committed together, so the video side never sees a half-updated frame.
module sprite_fetch_ctrl #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned BASE_ADDR = 6000,
  parameter int unsigned STRIDE    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 clear_ovr,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd_en,
  input  logic [WIDTH-1:0]     mem_data,
  output logic [WIDTH-1:0]     mx,
  output logic [WIDTH-1:0]     my,
  output logic [WIDTH-1:0]     p1x,
  output logic [WIDTH-1:0]     p1y,
  output logic [WIDTH-1:0]     p2x,
  output logic [WIDTH-1:0]     p2y,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int unsigned NSLOT  = 6;
  localparam int unsigned NSTAGE = NSLOT - 1;
  localparam int unsigned SLOT_W = 3;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic                 start_q, start_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 rd_en_q, rd_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic [WIDTH-1:0]     stage_q [NSTAGE];
  logic [WIDTH-1:0]     stage_d [NSTAGE];
  logic [WIDTH-1:0]     pos_q   [NSLOT];
  logic [WIDTH-1:0]     pos_d   [NSLOT];
  logic                 accept;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      start_q <= 1'b0;
      addr_q  <= ADDR_BITS'(BASE_ADDR);
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int unsigned k = 0; k < NSTAGE; k++) stage_q[k] <= '0;
      for (int unsigned k = 0; k < NSLOT; k++)  pos_q[k]   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      for (int unsigned k = 0; k < NSTAGE; k++) stage_q[k] <= stage_d[k];
      for (int unsigned k = 0; k < NSLOT; k++)  pos_q[k]   <= pos_d[k];
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    addr_d  = addr_q;
    rd_en_d = rd_en_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    for (int unsigned k = 0; k < NSTAGE; k++) stage_d[k] = stage_q[k];
    for (int unsigned k = 0; k < NSLOT; k++)  pos_d[k]   = pos_q[k];

    // A start is taken in IDLE or in the DRAIN cycle; one already pending counts as in flight.
    accept  = frame_start && (state_q != ISSUE) && !start_q;
    start_d = accept;
    if (frame_start && !accept) begin
      ovr_d = 1'b1;
    end else if (clear_ovr) begin
      ovr_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d = ISSUE;
          slot_d  = '0;
          addr_d  = ADDR_BITS'(BASE_ADDR);
          rd_en_d = 1'b1;
        end
      end
      ISSUE: begin
        // Data for the slot issued last cycle is on mem_data now.
        for (int unsigned k = 0; k < NSTAGE; k++) begin
          if (slot_q == SLOT_W'(k + 1)) stage_d[k] = mem_data;
        end
        if (slot_q == LAST_SLOT) begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
          addr_d = addr_q + ADDR_BITS'(STRIDE);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        slot_d  = '0;
        done_d  = 1'b1;
        for (int unsigned k = 0; k < NSTAGE; k++) pos_d[k] = stage_q[k];
        pos_d[NSLOT-1] = mem_data;
      end
      default: begin
        state_d = IDLE;
        rd_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign mem_addr   = addr_q;
  assign mem_rd_en  = rd_en_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
  assign mx         = pos_q[0];
  assign my         = pos_q[1];
  assign p1x        = pos_q[2];
  assign p1y        = pos_q[3];
  assign p2x        = pos_q[4];
  assign p2y        = pos_q[5];

endmodule
